// File: rtl/soc_glip_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | soc_glip_tx_framer                                                         |
// | Buffers one debug packet, then emits a length word plus payload to GLIP.   |
// | Optional macro SOC_GLIP_TX_FRAMER_STATS_EN adds pkt_cnt and busy outputs.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module soc_glip_tx_framer #(
    parameter int WIDTH       = 16,
    parameter int MAX_PKT_LEN = 12,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] glip_data,
    output logic             glip_valid,
    input  logic             glip_ready,
    output logic             err_oversize,
    output logic [CNT_W-1:0] drop_cnt
`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
    ,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             busy
`endif
);

    localparam int PTR_W = $clog2(MAX_PKT_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_DROP      = 3'd2,
        S_SEND_LEN  = 3'd3,
        S_SEND_DATA = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               in_ready_q, in_ready_d;
    logic               glip_valid_q, glip_valid_d;
    logic [WIDTH-1:0]   glip_data_q, glip_data_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [WIDTH-1:0]   mem_q [MAX_PKT_LEN];

    logic               w_in_acc;
    logic               w_out_acc;
    logic               w_mem_we;
    logic [PTR_W-1:0]   w_mem_wa;
    logic [PTR_W-1:0]   w_wr_inc;
    logic [PTR_W-1:0]   w_rd_inc;

`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
`endif

    assign w_in_acc  = in_valid & in_ready_q;
    assign w_out_acc = glip_valid_q & glip_ready;
    assign w_wr_inc  = wr_ptr_q + PTR_W'(1);
    assign w_rd_inc  = rd_ptr_q + PTR_W'(1);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        in_ready_d   = in_ready_q;
        glip_valid_d = glip_valid_q;
        glip_data_d  = glip_data_q;
        err_d        = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        w_mem_we     = 1'b0;
        w_mem_wa     = '0;
`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
        pkt_cnt_d    = pkt_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (w_in_acc) begin
                    w_mem_we = 1'b1;
                    w_mem_wa = '0;
                    wr_ptr_d = PTR_W'(1);
                    if (in_last) begin
                        state_d      = S_SEND_LEN;
                        in_ready_d   = 1'b0;
                        glip_valid_d = 1'b1;
                        glip_data_d  = WIDTH'(1);
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                in_ready_d = 1'b1;
                if (w_in_acc) begin
                    if (wr_ptr_q == PTR_W'(MAX_PKT_LEN)) begin
                        // Overflowing word: the packet is already lost.
                        if (in_last) begin
                            err_d      = 1'b1;
                            drop_cnt_d = (drop_cnt_q != {CNT_W{1'b1}}) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
                            state_d    = S_IDLE;
                            wr_ptr_d   = '0;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else begin
                        w_mem_we = 1'b1;
                        w_mem_wa = wr_ptr_q;
                        wr_ptr_d = w_wr_inc;
                        if (in_last) begin
                            state_d      = S_SEND_LEN;
                            in_ready_d   = 1'b0;
                            glip_valid_d = 1'b1;
                            glip_data_d  = WIDTH'(w_wr_inc);
                        end
                    end
                end
            end
            S_DROP: begin
                in_ready_d = 1'b1;
                if (w_in_acc && in_last) begin
                    err_d      = 1'b1;
                    drop_cnt_d = (drop_cnt_q != {CNT_W{1'b1}}) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
                    state_d    = S_IDLE;
                    wr_ptr_d   = '0;
                end
            end
            S_SEND_LEN: begin
                in_ready_d = 1'b0;
                if (w_out_acc) begin
                    rd_ptr_d    = '0;
                    state_d     = S_SEND_DATA;
                    glip_data_d = mem_q[0];
                end
            end
            S_SEND_DATA: begin
                in_ready_d = 1'b0;
                if (w_out_acc) begin
                    if (rd_ptr_q == wr_ptr_q - PTR_W'(1)) begin
                        state_d      = S_IDLE;
                        wr_ptr_d     = '0;
                        glip_valid_d = 1'b0;
                        glip_data_d  = '0;
                        in_ready_d   = 1'b1;
`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
                        pkt_cnt_d    = (pkt_cnt_q != {CNT_W{1'b1}}) ? pkt_cnt_q + CNT_W'(1) : pkt_cnt_q;
`endif
                    end else begin
                        rd_ptr_d    = w_rd_inc;
                        glip_data_d = mem_q[w_rd_inc];
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                wr_ptr_d     = '0;
                in_ready_d   = 1'b0;
                glip_valid_d = 1'b0;
                glip_data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            in_ready_q   <= 1'b0;
            glip_valid_q <= 1'b0;
            glip_data_q  <= '0;
            err_q        <= 1'b0;
            drop_cnt_q   <= '0;
`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
            pkt_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            in_ready_q   <= in_ready_d;
            glip_valid_q <= glip_valid_d;
            glip_data_q  <= glip_data_d;
            err_q        <= err_d;
            drop_cnt_q   <= drop_cnt_d;
`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
            pkt_cnt_q    <= pkt_cnt_d;
`endif
        end
    end

    // Payload storage carries no reset; wr_ptr alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_wa] <= in_data;
        end
    end

    assign in_ready     = in_ready_q;
    assign glip_valid   = glip_valid_q;
    assign glip_data    = glip_data_q;
    assign err_oversize = err_q;
    assign drop_cnt     = drop_cnt_q;
`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
    assign pkt_cnt      = pkt_cnt_q;
    assign busy         = (state_q == S_SEND_LEN) || (state_q == S_SEND_DATA);
`endif

endmodule
`default_nettype wire

// File: tb/tb_soc_glip_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_soc_glip_tx_framer                                                      |
// | Randomized self-checking bench with a packet-level reference model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_soc_glip_tx_framer;

    localparam int WIDTH = 16;
    localparam int MAX   = 12;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] glip_data;
    logic             glip_valid;
    logic             glip_ready = 1'b0;
    logic             err_oversize;
    logic [CNT_W-1:0] drop_cnt;
`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
    logic [CNT_W-1:0] pkt_cnt;
    logic             busy;
`endif

    soc_glip_tx_framer #(.WIDTH(WIDTH), .MAX_PKT_LEN(MAX), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .glip_data    (glip_data),
        .glip_valid   (glip_valid),
        .glip_ready   (glip_ready),
        .err_oversize (err_oversize),
        .drop_cnt     (drop_cnt)
`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
        ,
        .pkt_cnt      (pkt_cnt),
        .busy         (busy)
`endif
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    int               model_drops = 0;
    int               model_pkts = 0;
    int               err_seen = 0;
    int               gr_mode = 0;    // 0 always ready, 1 random, 2 pattern 1,0,0, 3 never
    int               gr_phase = 0;
    bit               bubbles = 1'b0;
    bit               hold_pending = 1'b0;
    logic [WIDTH-1:0] hold_data = '0;
    bit               accepted = 1'b0;
    int               low_cnt = 0;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Called at a falling edge: observes handshakes due at the next rising edge.
    task automatic step();
        case (gr_mode)
            0:       glip_ready = 1'b1;
            1:       glip_ready = 1'($urandom_range(0, 1));
            2: begin glip_ready = (gr_phase % 3 == 0); gr_phase++; end
            default: glip_ready = 1'b0;
        endcase
        if (rst && hold_pending) begin
            n_cmp++;
            if (glip_valid !== 1'b1 || glip_data !== hold_data) begin
                n_fail++;
                $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", glip_valid, glip_data, hold_data);
            end
        end
        hold_pending = rst && glip_valid && !glip_ready;
        hold_data    = glip_data;
        if (rst && glip_valid && glip_ready) got_q.push_back(glip_data);
        if (err_oversize) err_seen++;
`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
        n_cmp++;
        if (busy !== glip_valid) begin
            n_fail++;
            $display("FAIL busy: busy=%b required=%b", busy, glip_valid);
        end
`endif
        accepted = rst && in_valid && in_ready;
        @(negedge clk);
    endtask

    task automatic send_packet(input int len, input logic [WIDTH-1:0] base,
                               input logic [WIDTH-1:0] stride, input bit rnd);
        logic [WIDTH-1:0] words[$];
        logic [WIDTH-1:0] w;
        int guard;
        for (int i = 0; i < len; i++) begin
            w = rnd ? WIDTH'($urandom) : base + WIDTH'(i) * stride;
            if (bubbles && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = w;
            in_last  = (i == len - 1);
            guard    = 0;
            accepted = 1'b0;
            while (!accepted && guard < 300) begin
                step();
                guard++;
            end
            if (!accepted) begin
                n_cmp++;
                n_fail++;
                $display("FAIL in_accept_timeout word %0d: accepted=0 required=1", i);
            end
            words.push_back(w);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (len <= MAX) begin
            exp_q.push_back(WIDTH'(len));
            foreach (words[k]) exp_q.push_back(words[k]);
            model_pkts++;
        end else begin
            model_drops++;
        end
    endtask

    task automatic drain();
        int guard;
        guard   = 0;
        low_cnt = 0;
        while ((guard < 2 || got_q.size() < exp_q.size() || glip_valid) && guard < 600) begin
            if (!in_ready) low_cnt++;
            step();
            guard++;
        end
        if (guard >= 600) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d words required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic check_outputs(input string name);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d words required %0d", name, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s_word[%0d]: got %h required %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (err_seen !== model_drops) begin
            n_fail++;
            $display("FAIL %s_err_pulses: got %0d required %0d", name, err_seen, model_drops);
        end
        n_cmp++;
        if (drop_cnt !== CNT_W'(sat(model_drops))) begin
            n_fail++;
            $display("FAIL %s_drop_cnt: got %0d required %0d", name, drop_cnt, sat(model_drops));
        end
`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
        n_cmp++;
        if (pkt_cnt !== CNT_W'(sat(model_pkts))) begin
            n_fail++;
            $display("FAIL %s_pkt_cnt: got %0d required %0d", name, pkt_cnt, sat(model_pkts));
        end
`endif
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) step();
        rst          = 1'b1;
        model_drops  = 0;
        model_pkts   = 0;
        err_seen     = 0;
        hold_pending = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_cmp++;
        if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        n_cmp++;
        if (glip_valid !== 1'b0) begin n_fail++; $display("FAIL reset_glip_valid: got %b required 0", glip_valid); end
        n_cmp++;
        if (glip_data !== '0)    begin n_fail++; $display("FAIL reset_glip_data: got %h required 0000", glip_data); end
        n_cmp++;
        if (err_oversize !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err_oversize); end
        n_cmp++;
        if (drop_cnt !== '0)     begin n_fail++; $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt); end
        rst = 1'b1;
        step();
        n_cmp++;
        if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
        err_seen = 0;
    endtask

    task automatic test_single_word();
        gr_mode = 0;
        send_packet(1, 16'h1234, 16'h0000, 1'b0);
        n_cmp++;
        if (glip_valid !== 1'b1 || glip_data !== 16'h0001) begin
            n_fail++;
            $display("FAIL single_latency: valid=%b data=%h required valid=1 data=0001", glip_valid, glip_data);
        end
        drain();
        n_cmp++;
        if (low_cnt !== 2) begin
            n_fail++;
            $display("FAIL single_in_ready_low: got %0d cycles required 2", low_cnt);
        end
        check_outputs("single");
    endtask

    task automatic test_full_length();
        gr_mode = 0;
        send_packet(MAX, 16'hA000, 16'h0001, 1'b0);
        drain();
        check_outputs("full_length");
    endtask

    task automatic test_oversize();
        gr_mode = 0;
        send_packet(MAX + 1, '0, '0, 1'b1);
        drain();
        check_outputs("oversize");
        send_packet(2, 16'h5555, 16'h1111, 1'b0);
        drain();
        check_outputs("after_drop");
    endtask

    task automatic test_backpressure();
        gr_mode  = 2;
        gr_phase = 0;
        send_packet(3, '0, '0, 1'b1);
        drain();
        check_outputs("backpressure");
        gr_mode = 0;
    endtask

    task automatic test_back_to_back();
        int guard;
        gr_mode = 0;
        send_packet(3, '0, '0, 1'b1);
        guard = 0;
        while (glip_valid && guard < 50) begin
            step();
            guard++;
        end
        n_cmp++;
        if (glip_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: valid=%b in_ready=%b required valid=0 in_ready=1", glip_valid, in_ready);
        end
        send_packet(2, '0, '0, 1'b1);
        drain();
        check_outputs("back_to_back");
    endtask

    task automatic test_reset_mid_send();
        logic [WIDTH-1:0] len_word;
        gr_mode = 3;
        send_packet(4, '0, '0, 1'b1);
        gr_mode = 0;
        step();
        rst     = 1'b0;
        gr_mode = 3;
        step();
        n_cmp++;
        if (glip_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_valid: got %b required 0", glip_valid);
        end
        len_word = exp_q[0];
        exp_q.delete();
        exp_q.push_back(len_word);
        model_drops = 0;
        model_pkts  = 0;
        err_seen    = 0;
        check_outputs("reset_mid");
        rst     = 1'b1;
        gr_mode = 0;
        step();
        send_packet(1, '0, '0, 1'b1);
        drain();
        check_outputs("after_reset");
    endtask

    task automatic test_random();
        bubbles = 1'b1;
        gr_mode = 1;
        for (int p = 0; p < 25; p++) begin
            send_packet($urandom_range(1, MAX + 2), '0, '0, 1'b1);
        end
        drain();
        check_outputs("random");
        bubbles = 1'b0;
        gr_mode = 0;
    endtask

`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
    task automatic test_stats();
        do_reset(2);
        gr_mode = 1;
        send_packet(3, '0, '0, 1'b1);
        send_packet(MAX + 1, '0, '0, 1'b1);
        send_packet(1, '0, '0, 1'b1);
        send_packet(MAX, '0, '0, 1'b1);
        drain();
        check_outputs("stats");
        gr_mode = 0;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single_word();
        test_full_length();
        test_oversize();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_send();
        test_random();
`ifdef SOC_GLIP_TX_FRAMER_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_glip_tx_framer.md
Name: soc_glip_tx_framer

Overview:
- Host-side stage directly upstream of the system's GLIP input channel (c_glip_in).
- Accepts debug packets as 16-bit words with a last marker, buffers one whole packet, then emits it on the GLIP channel as a length word followed by the payload words.
- Packets longer than the debug packet limit are dropped and flagged.
- Lets benches and host bridges inject debug traffic without hand-building length headers.

Parameters:
- WIDTH, 16, GLIP/debug flit width in bits.
- MAX_PKT_LEN, 12, maximum payload words per packet; matches DEBUG_MAX_PKT_LEN.
- CNT_W, 8, width of the drop and statistics counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- in_data  in  WIDTH  host payload word.
- in_last  in  1  marks the final word of a packet.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  framer accepts the word this cycle.
- glip_data  out  WIDTH  word to c_glip_in.
- glip_valid  out  1  glip_data valid.
- glip_ready  in  1  c_glip_in accepts the word.
- err_oversize  out  1  one-cycle pulse when a packet is dropped.
- drop_cnt  out  CNT_W  saturating count of dropped packets.

Behaviour:
- Handshake: a transfer occurs when valid & ready are both high at a rising edge. Once glip_valid is raised, glip_data is held stable until accepted; glip_valid is never withdrawn before acceptance.
- Reset (rst=0): state=IDLE, wr_ptr=0, rd_ptr=0, in_ready=0, glip_valid=0, glip_data=0, err_oversize=0, drop_cnt=0. The stats counter also clears when compiled in.
- Reset asserted mid-packet in any state discards the partial or in-flight packet. No trailing words are emitted after reset release.
- Buffer: MAX_PKT_LEN x WIDTH register array. wr_ptr counts accepted words.
- States:
  - IDLE: in_ready=1. On accept: store the word at index 0, wr_ptr=1.
    - If in_last: go to SEND_LEN.
    - Else: go to FILL.
  - FILL: in_ready=1. On accept:
    - If wr_ptr==MAX_PKT_LEN (the word would overflow): discard it and enter DROP, or complete the drop immediately if in_last (see DROP).
    - Else: store the word, wr_ptr+=1. If in_last, go to SEND_LEN.
  - DROP: in_ready=1. Accept and discard words until the word with in_last is accepted. On that cycle:
    - err_oversize pulses high for exactly one cycle, on the cycle after the last word is accepted.
    - drop_cnt increments, saturating at all-ones.
    - state returns to IDLE and wr_ptr is cleared.
  - SEND_LEN: in_ready=0. glip_valid=1 with glip_data=wr_ptr, zero-extended to WIDTH. On glip_ready: rd_ptr=0, go to SEND_DATA.
  - SEND_DATA: in_ready=0. glip_valid=1 with glip_data=buf[rd_ptr]. On glip_ready:
    - If rd_ptr==wr_ptr-1: go to IDLE, clear wr_ptr, deassert glip_valid.
    - Else: rd_ptr+=1.
- Latency: the length word is valid on the cycle after the last input word is accepted.
- Throughput: one output word per cycle when glip_ready is held high. A packet of N words occupies N+1 GLIP cycles.
- in_ready is 0 during SEND_LEN and SEND_DATA. There is no overlap of fill and drain; one packet is in flight at a time.
- Packet of exactly MAX_PKT_LEN words is legal and sent intact. Packet of MAX_PKT_LEN+1 words is dropped.
- Zero-length packets cannot occur, since every packet carries at least one word.
- Back-to-back packets: the next packet is accepted starting in the cycle after the final payload word transfers (IDLE, in_ready=1).

Optional Feature:
- Macro SOC_GLIP_TX_FRAMER_STATS_EN.
- When defined:
  - Adds output pkt_cnt (CNT_W), a saturating count of packets fully sent, incremented on acceptance of the final payload word.
  - Adds output busy (1), high in SEND_LEN and SEND_DATA.
- When undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
- Single word: in 0x1234 with last, glip_ready=1 -> glip sees 0x0001 then 0x1234 on consecutive cycles; in_ready low for 2 cycles.
- Full-length packet: 12 words 0xA000..0xA00B -> glip sees 0x000C then 0xA000..0xA00B in order; drop_cnt stays 0.
- Oversize: 13 words -> no glip_valid; err_oversize single pulse; drop_cnt=1. A following 2-word packet 0x5555, 0x6666 emits 0x0002, 0x5555, 0x6666.
- Backpressure: 3-word packet with glip_ready toggling 1,0,0,1,... -> glip_data stable while stalled; output sequence 0x0003, w0, w1, w2 with no duplicates or losses.
- Reset mid-send: assert rst=0 after the length word transfers in a 4-word packet -> glip_valid=0 next cycle; after release, a new 1-word packet emits 0x0001 and its word only.
- Stats (macro defined): three good packets plus one oversize -> pkt_cnt=3, drop_cnt=1; busy high only in send states.
